// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state enum, opcode constants and datapath select encodings for multicycle_control
package multicycle_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_BR, S_EXEC_J,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_ILLEGAL
  } state_e;
  localparam logic [2:0] OP_3R  = 3'b000;
  localparam logic [2:0] OP_BR  = 3'b001;
  localparam logic [2:0] OP_RI  = 3'b010;
  localparam logic [2:0] OP_L   = 3'b011;
  localparam logic [2:0] OP_J   = 3'b100;
  localparam logic [2:0] OP_S   = 3'b101;
  localparam logic [2:0] OP_I   = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_CONST2 = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
endpackage

// File: rtl/ctrl_perf_counter.sv
// ctrl_perf_counter: wrapping 16-bit cycle and retired-instruction counters
module ctrl_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_inc_i,
  output logic [15:0] cycle_count_o,
  output logic [15:0] instr_count_o
);
  logic [15:0] cycle_q, cycle_d, instr_q, instr_d;
  assign cycle_d = cycle_q + 16'd1;
  assign instr_d = instr_inc_i ? instr_q + 16'd1 : instr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end
  assign cycle_count_o = cycle_q;
  assign instr_count_o = instr_q;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/write-back sequencer for the 16-bit processor
// MULTICYCLE_PERF_CNT_EN adds cycle and instruction counter outputs.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] input_instr,
  input  logic        input_mem_ready,
  input  logic        input_zero,
  output logic [2:0]  output_reg_readA_address,
  output logic [2:0]  output_reg_readB_address,
  output logic        output_reg_write,
  output logic [2:0]  output_reg_write_address,
  output logic        output_memToReg,
  output logic        output_branch,
  output logic        output_pc_write,
  output logic        output_ir_write,
  output logic        output_mem_read,
  output logic        output_mem_write,
  output logic        output_iord,
  output logic        output_alu_src_a,
  output logic [1:0]  output_alu_src_b,
  output logic [1:0]  output_alu_op,
  output logic [1:0]  output_pc_source,
  output logic        output_illegal
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [15:0] output_cycle_count,
  output logic [15:0] output_instr_count
`endif
);
  state_e state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0] opc, rd, rs1, rs2;
  logic unused_funct;
  assign opc = ir_q[2:0];
  assign rd  = ir_q[5:3];
  assign rs1 = ir_q[8:6];
  assign rs2 = ir_q[11:9];
  // FUNCT bits feed the ALU decoder in the datapath, not this controller
  assign unused_funct = ^ir_q[15:12];
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    output_reg_write = 1'b0;
    output_reg_write_address = '0;
    output_memToReg = 1'b0;
    output_branch = 1'b0;
    output_pc_write = 1'b0;
    output_ir_write = 1'b0;
    output_mem_read = 1'b0;
    output_mem_write = 1'b0;
    output_iord = 1'b0;
    output_alu_src_a = 1'b0;
    output_alu_src_b = SRC_B_REG;
    output_alu_op = ALU_ADD;
    output_pc_source = PC_SRC_ALU;
    output_illegal = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        output_mem_read = 1'b1;
        output_alu_src_b = SRC_B_CONST2;
        output_ir_write = input_mem_ready;
        output_pc_write = input_mem_ready;
        state_d = input_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        output_alu_src_b = SRC_B_IMM;
        case (opc)
          OP_3R:       state_d = S_EXEC_R;
          OP_BR:       state_d = S_EXEC_BR;
          OP_RI, OP_L: state_d = S_EXEC_I;
          OP_J:        state_d = S_EXEC_J;
          OP_S, OP_I:  state_d = S_MEM_ADDR;
          default:     state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        output_alu_src_a = 1'b1;
        output_alu_op = ALU_FUNCT;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        output_alu_src_a = 1'b1;
        output_alu_src_b = SRC_B_IMM;
        output_alu_op = (opc == OP_L) ? ALU_PASS_B : ALU_ADD;
        state_d = S_WB_ALU;
      end
      S_EXEC_BR: begin
        output_branch = 1'b1;
        output_alu_src_a = 1'b1;
        output_alu_op = ALU_SUB;
        output_pc_source = PC_SRC_ALUOUT;
        output_pc_write = input_zero;
        state_d = S_FETCH;
      end
      S_EXEC_J: begin
        output_pc_source = PC_SRC_JUMP;
        output_pc_write = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        output_alu_src_a = 1'b1;
        output_alu_src_b = SRC_B_IMM;
        state_d = (opc == OP_I) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        output_mem_read = 1'b1;
        output_iord = 1'b1;
        state_d = input_mem_ready ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        output_mem_write = 1'b1;
        output_iord = 1'b1;
        state_d = input_mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_WB_ALU: begin
        output_reg_write = 1'b1;
        output_reg_write_address = rd;
        state_d = S_FETCH;
      end
      S_WB_MEM: begin
        output_reg_write = 1'b1;
        output_reg_write_address = rd;
        output_memToReg = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: output_illegal = 1'b1;
      default: state_d = S_IDLE;
    endcase
    output_reg_readA_address = (state_q == S_IDLE) ? 3'd0 : rs1;
    output_reg_readB_address = (state_q == S_IDLE) ? 3'd0 : output_branch ? rd : rs2;
    ir_d = output_ir_write ? input_instr : ir_q;
  end
`ifdef MULTICYCLE_PERF_CNT_EN
  logic instr_inc;
  // an instruction retires whenever control returns to FETCH from a later phase
  assign instr_inc = (state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH);
  ctrl_perf_counter u_perf (
    .clk           (CLK),
    .rst           (RST),
    .instr_inc_i   (instr_inc),
    .cycle_count_o (output_cycle_count),
    .instr_count_o (output_instr_count)
  );
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; a per-instruction phase model queues expected control words
module tb_multicycle_control;
  logic CLK = 1'b0, RST = 1'b1;
  logic [15:0] input_instr = '0;
  logic input_mem_ready = 1'b0, input_zero = 1'b0;
  logic [2:0] ra_o, rb_o, wa_o;
  logic rw_o, m2r_o, br_o, pcw_o, irw_o, mr_o, mw_o, io_o, sa_o, ill_o;
  logic [1:0] sb_o, op_o, ps_o;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [15:0] cyc_o, ins_o;
`endif
  typedef struct packed {
    logic [2:0] ra, rb;
    logic rw;
    logic [2:0] wa;
    logic m2r, br, pcw, irw, mr, mw, io, sa;
    logic [1:0] sb, op, ps;
    logic ill;
  } ctl_t;
  typedef struct {
    ctl_t w;
    string nm;
  } exp_t;
  exp_t q[$];
  ctl_t act;
  logic [15:0] ir_m = '0;
  int checks = 0, fails = 0;
  multicycle_control dut (
    .CLK(CLK), .RST(RST), .input_instr(input_instr), .input_mem_ready(input_mem_ready),
    .input_zero(input_zero), .output_reg_readA_address(ra_o), .output_reg_readB_address(rb_o),
    .output_reg_write(rw_o), .output_reg_write_address(wa_o), .output_memToReg(m2r_o),
    .output_branch(br_o), .output_pc_write(pcw_o), .output_ir_write(irw_o),
    .output_mem_read(mr_o), .output_mem_write(mw_o), .output_iord(io_o),
    .output_alu_src_a(sa_o), .output_alu_src_b(sb_o), .output_alu_op(op_o),
    .output_pc_source(ps_o), .output_illegal(ill_o)
`ifdef MULTICYCLE_PERF_CNT_EN
    , .output_cycle_count(cyc_o), .output_instr_count(ins_o)
`endif
  );
  always #5 CLK = ~CLK;
  assign act = {ra_o, rb_o, rw_o, wa_o, m2r_o, br_o, pcw_o, irw_o, mr_o, mw_o, io_o, sa_o, sb_o, op_o, ps_o, ill_o};
  always @(negedge CLK) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act !== e.w) begin
        fails++;
        $display("FAIL %s @%0t: got %h expected %h", e.nm, $time, act, e.w);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic rb1();
    return 1'($urandom);
  endfunction
  function automatic ctl_t base();
    ctl_t c;
    c = '0;
    c.ra = ir_m[8:6];
    c.rb = ir_m[11:9];
    return c;
  endfunction
  task automatic step(input ctl_t w, input string nm, input logic rdy, input logic [15:0] ins, input logic z);
    exp_t e;
    input_mem_ready = rdy;
    input_instr = ins;
    input_zero = z;
    e.w = w;
    e.nm = nm;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask
  task automatic reset_cycle(input ctl_t w, input string nm);
    RST = 1'b1;
    step(w, nm, 1'b0, 16'($urandom), rb1());
    RST = 1'b0;
    ir_m = '0;
    step('0, "IDLE", rb1(), 16'($urandom), rb1());
  endtask
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic z, input logic abort);
    ctl_t c;
    logic [2:0] opc;
    opc = ins[2:0];
    c = base(); c.mr = 1'b1; c.sb = 2'b01;
    for (int i = 0; i < fw; i++) step(c, "FETCH_WAIT", 1'b0, 16'($urandom), rb1());
    c.irw = 1'b1; c.pcw = 1'b1;
    step(c, "FETCH", 1'b1, ins, rb1());
    ir_m = ins;
    c = base(); c.sb = 2'b10;
    step(c, "DECODE", rb1(), 16'($urandom), rb1());
    if (opc == 3'd7) begin
      c = base(); c.ill = 1'b1;
      for (int i = 0; i < 10; i++) step(c, "ILLEGAL", rb1(), 16'($urandom), rb1());
      reset_cycle(c, "ILLEGAL_RST");
    end else if (opc == 3'd1) begin
      c = base(); c.rb = ins[5:3]; c.br = 1'b1; c.sa = 1'b1; c.op = 2'b01; c.ps = 2'b01; c.pcw = z;
      step(c, "EXEC_BR", rb1(), 16'($urandom), z);
    end else if (opc == 3'd4) begin
      c = base(); c.ps = 2'b10; c.pcw = 1'b1;
      step(c, "EXEC_J", rb1(), 16'($urandom), rb1());
    end else if (opc == 3'd5 || opc == 3'd6) begin
      c = base(); c.sa = 1'b1; c.sb = 2'b10;
      step(c, "MEM_ADDR", rb1(), 16'($urandom), rb1());
      c = base(); c.io = 1'b1;
      if (opc == 3'd6) c.mr = 1'b1; else c.mw = 1'b1;
      if (abort) begin
        reset_cycle(c, "MEM_ABORT");
        return;
      end
      for (int i = 0; i < mw; i++) step(c, "MEM_WAIT", 1'b0, 16'($urandom), rb1());
      step(c, "MEM", 1'b1, 16'($urandom), rb1());
      if (opc == 3'd6) begin
        c = base(); c.rw = 1'b1; c.wa = ins[5:3]; c.m2r = 1'b1;
        step(c, "WB_MEM", rb1(), 16'($urandom), rb1());
      end
    end else begin
      c = base(); c.sa = 1'b1;
      if (opc == 3'd0) c.op = 2'b10;
      else begin
        c.sb = 2'b10;
        c.op = (opc == 3'd3) ? 2'b11 : 2'b00;
      end
      step(c, "EXEC", rb1(), 16'($urandom), rb1());
      c = base(); c.rw = 1'b1; c.wa = ins[5:3];
      step(c, "WB_ALU", rb1(), 16'($urandom), rb1());
    end
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    step('0, "IDLE", 1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 3; i++) run_instr(16'b0000_010_001_011_000, 0, 0, 1'b0, 1'b0);
`ifdef MULTICYCLE_PERF_CNT_EN
    checks += 2;
    if (cyc_o !== 16'd13) begin fails++; $display("FAIL cycle_count: got %0d expected 13", cyc_o); end
    if (ins_o !== 16'd3) begin fails++; $display("FAIL instr_count: got %0d expected 3", ins_o); end
`endif
    run_instr(16'b1010_110_101_100_110, 0, 2, 1'b0, 1'b0);
    run_instr(16'b0000_001_010_111_001, 0, 0, 1'b1, 1'b0);
    run_instr(16'b0000_011_100_101_001, 1, 0, 1'b0, 1'b0);
    run_instr(16'b0000_000_000_000_100, 0, 0, 1'b0, 1'b0);
    run_instr(16'b0101_111_110_010_011, 2, 0, 1'b0, 1'b0);
    run_instr(16'b0000_100_011_001_101, 0, 1, 1'b0, 1'b0);
    run_instr(16'b0000_100_011_001_101, 0, 0, 1'b0, 1'b1);
    run_instr(16'b0000_010_101_110_110, 1, 0, 1'b0, 1'b1);
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      ins[2:0] = 3'($urandom_range(0, 6));
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), rb1(), ($urandom_range(0, 7) == 0));
    end
    run_instr(16'b1100_101_011_110_111, 0, 0, 1'b0, 1'b0);
    run_instr(16'b0000_010_001_011_000, 0, 0, 1'b0, 1'b0);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
